// File: rtl/ind_driver.sv
// Purpose: drives a multiplexed 7-segment indicator from the ALU result word and mode code (binary->BCD, sign/dp/Err/blanking, digit scan).
// Latency: IND_1+2 clocks from an input change to new digits on seg, plus the wait for the scan to reach each position.
// Backpressure: none; inputs arriving mid-conversion are re-compared in IDLE, so the last value always wins.
//
// Ports: clk_IND (single clock), rst_n (async, active-low), ind_1 (unsigned result),
//        control (0 plus, 1 minus, 2 divide-by-zero, 4 value x100, other = plus),
//        seg (active-low, seg[7] = dp, seg[6:0] = g..a), an (active-low digit enables, an[0] = units),
//        busy (high while a conversion is in flight).
// Optional feature: IND_BLINK_ERR_EN blinks the whole indicator in the divide-by-zero mode.
module ind_driver #(
    parameter int IND_1    = 11,
    parameter int CONTROL  = 3,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 50000,
    parameter int BLINK_W  = 24
) (
    input  logic               clk_IND,
    input  logic               rst_n,
    input  logic [IND_1-1:0]   ind_1,
    input  logic [CONTROL-1:0] control,
    output logic [7:0]         seg,
    output logic [DIGITS-1:0]  an,
    output logic               busy
);
    localparam int CNT_W = $clog2(IND_1 + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;

    generate
        if (IND_1 < 1 || IND_1 > 13 || SCAN_DIV < 2 || DIGITS < 5 || BLINK_W < 1) begin : g_bad_param
            $error("ind_driver: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {M_PLUS, M_MINUS, M_ERR, M_X100} mode_t;

    function automatic mode_t decode_mode(input logic [CONTROL-1:0] c);
        case (32'(c))
            1:       decode_mode = M_MINUS;
            2:       decode_mode = M_ERR;
            4:       decode_mode = M_X100;
            default: decode_mode = M_PLUS;
        endcase
    endfunction

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        case (d)
            4'd0:    glyph_of = 7'b1000000;
            4'd1:    glyph_of = 7'b1111001;
            4'd2:    glyph_of = 7'b0100100;
            4'd3:    glyph_of = 7'b0110000;
            4'd4:    glyph_of = 7'b0011001;
            4'd5:    glyph_of = 7'b0010010;
            4'd6:    glyph_of = 7'b0000010;
            4'd7:    glyph_of = 7'b1111000;
            4'd8:    glyph_of = 7'b0000000;
            4'd9:    glyph_of = 7'b0010000;
            default: glyph_of = G_BLANK;
        endcase
    endfunction

    state_t             state, state_nxt;
    logic [IND_1-1:0]   snap_val;
    logic [CONTROL-1:0] snap_ctl;
    logic               snap_vld;
    logic [IND_1-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        work_bcd, work_adj, disp_bcd;
    mode_t              disp_mode;
    logic               changed;

    logic [PRE_W-1:0]   pre;
    logic [IDX_W-1:0]   idx;
    logic               scan_on;
    logic               blank_all;

    assign changed = !snap_vld || ({ind_1, control} != {snap_val, snap_ctl});

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        work_adj = work_bcd;
        for (int n = 0; n < 4; n++) begin
            if (work_bcd[n*4 +: 4] >= 4'd5)
                work_adj[n*4 +: 4] = work_bcd[n*4 +: 4] + 4'd3;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_IND or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (changed) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == ST_SHIFT) || (state == ST_DONE);
    end

    // Conversion datapath and display registers
    always_ff @(posedge clk_IND or negedge rst_n) begin
        if (!rst_n) begin
            snap_val  <= '0;
            snap_ctl  <= '0;
            snap_vld  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            work_bcd  <= '0;
            disp_bcd  <= '0;
            disp_mode <= M_PLUS;
        end else begin
            case (state)
                ST_IDLE: if (changed) begin
                    snap_val <= ind_1;
                    snap_ctl <= control;
                    snap_vld <= 1'b1;
                    shreg    <= ind_1;
                    work_bcd <= '0;
                    cnt      <= CNT_W'(IND_1);
                end
                ST_SHIFT: begin
                    work_bcd <= {work_adj[14:0], shreg[IND_1-1]};
                    shreg    <= shreg << 1;
                    cnt      <= cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    disp_bcd  <= work_bcd;
                    disp_mode <= decode_mode(snap_ctl);
                end
                default: ;
            endcase
        end
    end

`ifdef IND_BLINK_ERR_EN
    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk_IND or negedge rst_n) begin
        if (!rst_n) blink_cnt <= '0;
        else        blink_cnt <= blink_cnt + BLINK_W'(1);
    end

    assign blank_all = (disp_mode == M_ERR) && blink_cnt[BLINK_W-1];
`else
    assign blank_all = 1'b0;
`endif

    // Scan: the first prescaler wrap only enables the digit drivers, later wraps advance the position.
    always_ff @(posedge clk_IND or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            scan_on <= 1'b0;
        end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
            pre     <= '0;
            scan_on <= 1'b1;
            if (scan_on)
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Content of the currently scanned position.
    logic [3:0] lit_mask;
    logic [3:0] digit;
    logic [6:0] glyph;
    logic       dp_on;

    always_comb begin
        // lit_mask[k]: position k shows its digit (leading zeros blanked, units always lit).
        lit_mask[3] = (disp_bcd[15:12] != 4'd0);
        lit_mask[2] = lit_mask[3] || (disp_bcd[11:8] != 4'd0);
        lit_mask[1] = lit_mask[2] || (disp_bcd[7:4] != 4'd0);
        lit_mask[0] = 1'b1;
        if (disp_mode == M_X100)
            lit_mask[2:0] = 3'b111;

        digit = 4'd0;
        glyph = G_BLANK;
        dp_on = 1'b0;
        if (disp_mode == M_ERR) begin
            if (idx == IDX_W'(2))      glyph = G_E;
            else if (idx == IDX_W'(1)) glyph = G_R;
            else if (idx == IDX_W'(0)) glyph = G_R;
        end else if (idx == IDX_W'(DIGITS - 1)) begin
            if (disp_mode == M_MINUS) glyph = G_MINUS;
        end else if (idx < IDX_W'(4)) begin
            digit = disp_bcd[{idx[1:0], 2'b00} +: 4];
            if (lit_mask[idx[1:0]]) glyph = glyph_of(digit);
            dp_on = (disp_mode == M_X100) && (idx == IDX_W'(2));
        end
    end

    always_ff @(posedge clk_IND or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= {~dp_on, glyph};
            an  <= (scan_on && !blank_all) ? ~(DIGITS'(1) << idx) : '1;
        end
    end

endmodule
